// File: rtl/sonar_eco_gerador_pkg.sv
// Shared definitions for the HC-SR04 echo emulator: state codes, default 50 MHz timing, distance limit.
package sonar_eco_gerador_pkg;

    typedef enum logic [2:0] {
        ST_INICIAL      = 3'd0,
        ST_MEDE_TRIGGER = 3'd1,
        ST_ESPERA       = 3'd2,
        ST_ECO          = 3'd3,
        ST_FIM          = 3'd4,
        ST_HOLDOFF      = 3'd5
    } estado_t;

    localparam int unsigned TICKS_POR_CM_PADRAO = 2941;
    localparam int unsigned MIN_TRIGGER_PADRAO  = 500;
    localparam int unsigned ATRASO_ECO_PADRAO   = 500;
    localparam int unsigned HOLDOFF_PADRAO      = 3000000;
    localparam int unsigned MAX_CM_PADRAO       = 400;

    // Bit width needed to hold 0..m-1, never below one bit.
    function automatic int unsigned largura(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sonar_eco_gerador_contador_m.sv
// Modulo-M counter: zera clears (priority), conta advances and wraps; fim flags the terminal value M-1.
module contador_m
    import sonar_eco_gerador_pkg::*;
#(
    parameter int unsigned M = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   zera,
    input  logic                   conta,
    output logic [largura(M)-1:0]  q,
    output logic                   fim
);

    localparam int unsigned W = largura(M);

    assign fim = (q == W'(M - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= fim ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/sonar_eco_gerador.sv
// HC-SR04 echo emulator: validates trigger width, waits, then drives echo for distancia x TICKS_POR_CM cycles.
// Optional build macro ECO_HOLDOFF_EN adds a post-measurement holdoff state.
module sonar_eco_gerador
    import sonar_eco_gerador_pkg::*;
#(
    parameter int unsigned TICKS_POR_CM = TICKS_POR_CM_PADRAO,
    parameter int unsigned LARGURA_DIST = 9,
    parameter int unsigned MAX_CM       = MAX_CM_PADRAO,
    parameter int unsigned MIN_TRIGGER  = MIN_TRIGGER_PADRAO,
    parameter int unsigned ATRASO_ECO   = ATRASO_ECO_PADRAO,
    parameter int unsigned HOLDOFF      = HOLDOFF_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic [LARGURA_DIST-1:0] distancia,
    output logic                    echo,
    output logic                    ocupado,
    output logic                    pronto,
    output logic                    erro_trigger,
    output logic [2:0]              db_estado
);

    localparam int unsigned TW = largura(MIN_TRIGGER + 1);
    localparam int unsigned AW = largura(ATRASO_ECO);
    localparam int unsigned KW = largura(TICKS_POR_CM);
    localparam int unsigned CW = largura(MAX_CM + 1);

    estado_t         estado, proximo;
    logic            trig_m, trig_s;
    logic            trig_fim, atraso_fim, tick_fim, cm_ultimo;
    logic [TW-1:0]   trig_unused;
    logic [AW-1:0]   atraso_unused;
    logic [KW-1:0]   tick_unused;
    logic [CW-1:0]   cm_q, dist_lat, dist_limitada;
    logic [31:0]     dist_ext;
    logic            trig_ativo, rejeita, aceita;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
        end
    end

    // Trigger counter starts at 1 on the acceptance cycle and saturates at MIN_TRIGGER.
    assign trig_ativo = trig_s && (estado == ST_INICIAL || estado == ST_MEDE_TRIGGER);
    assign aceita     = (estado == ST_MEDE_TRIGGER) && !trig_s && trig_fim;
    assign rejeita    = (estado == ST_MEDE_TRIGGER) && !trig_s && !trig_fim;

    contador_m #(.M(MIN_TRIGGER + 1)) u_trig (
        .clock(clock), .reset(reset), .zera(!trig_ativo), .conta(trig_ativo && !trig_fim),
        .q(trig_unused), .fim(trig_fim)
    );

    contador_m #(.M(ATRASO_ECO)) u_atraso (
        .clock(clock), .reset(reset), .zera(estado != ST_ESPERA), .conta(estado == ST_ESPERA),
        .q(atraso_unused), .fim(atraso_fim)
    );

    contador_m #(.M(TICKS_POR_CM)) u_tick (
        .clock(clock), .reset(reset), .zera(estado != ST_ECO), .conta(estado == ST_ECO),
        .q(tick_unused), .fim(tick_fim)
    );

    contador_m #(.M(MAX_CM + 1)) u_cm (
        .clock(clock), .reset(reset), .zera(estado != ST_ECO), .conta((estado == ST_ECO) && tick_fim),
        .q(cm_q), .fim()
    );

`ifdef ECO_HOLDOFF_EN
    logic                         hold_fim;
    logic [largura(HOLDOFF)-1:0]  hold_unused;

    contador_m #(.M(HOLDOFF)) u_hold (
        .clock(clock), .reset(reset), .zera(estado != ST_HOLDOFF), .conta(estado == ST_HOLDOFF),
        .q(hold_unused), .fim(hold_fim)
    );
`endif

    assign dist_ext      = 32'(distancia);
    assign dist_limitada = (dist_ext > MAX_CM) ? CW'(MAX_CM) :
                           (dist_ext == 32'd0) ? CW'(1) : CW'(dist_ext);
    // Exit on the wrap that completes the last cm, so echo spans exactly dist_lat full cm periods.
    assign cm_ultimo     = tick_fim && (cm_q == dist_lat - CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro_trigger <= 1'b0;
            dist_lat     <= '0;
        end else begin
            erro_trigger <= rejeita;
            if (aceita) dist_lat <= dist_limitada;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ST_INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            ST_INICIAL:      if (trig_s) proximo = ST_MEDE_TRIGGER;
            ST_MEDE_TRIGGER: if (!trig_s) proximo = trig_fim ? ST_ESPERA : ST_INICIAL;
            ST_ESPERA:       if (atraso_fim) proximo = ST_ECO;
            ST_ECO:          if (cm_ultimo) proximo = ST_FIM;
`ifdef ECO_HOLDOFF_EN
            ST_FIM:          proximo = ST_HOLDOFF;
            ST_HOLDOFF:      if (hold_fim) proximo = ST_INICIAL;
`else
            ST_FIM:          proximo = ST_INICIAL;
`endif
            default:         proximo = ST_INICIAL;
        endcase
    end

    always_comb begin
        echo    = 1'b0;
        ocupado = 1'b0;
        pronto  = 1'b0;
        case (estado)
            ST_ESPERA: ocupado = 1'b1;
            ST_ECO:    begin echo = 1'b1; ocupado = 1'b1; end
            ST_FIM:    begin pronto = 1'b1; ocupado = 1'b1; end
            default:   ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_sonar_eco_gerador.sv
// Self-checking bench for sonar_eco_gerador in its small-parameter build; holdoff scenario only with ECO_HOLDOFF_EN.
module tb_sonar_eco_gerador;

    localparam int TPC  = 4;
    localparam int MINT = 5;
    localparam int ATR  = 3;
    localparam int MAXC = 10;
    localparam int HOLD = 20;
    localparam int LD   = 9;
    // trigger input fall -> 2 sync flops -> 1 decision cycle -> ATR delay cycles
    localparam int LAT  = 3 + ATR;
    localparam int BUDGET = LAT + MAXC * TPC + 8;
`ifdef ECO_HOLDOFF_EN
    localparam int GAP = HOLD + 4;
`else
    localparam int GAP = 3;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          trigger = 1'b0;
    logic [LD-1:0] distancia = '0;
    logic          echo, ocupado, pronto, erro_trigger;
    logic [2:0]    db_estado;

    int vectors = 0;
    int miscompares = 0;
    int m_rise, m_width, m_npronto, m_pronto_k, m_nerro, m_nocup;

    sonar_eco_gerador #(
        .TICKS_POR_CM(TPC), .LARGURA_DIST(LD), .MAX_CM(MAXC),
        .MIN_TRIGGER(MINT), .ATRASO_ECO(ATR), .HOLDOFF(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
        .echo(echo), .ocupado(ocupado), .pronto(pronto),
        .erro_trigger(erro_trigger), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic int exp_width(input int d);
        int c;
        c = (d > MAXC) ? MAXC : d;
        if (c == 0) c = 1;
        return c * TPC;
    endfunction

    // Pulse trigger for h cycles, then observe echo/pronto/erro until pronto settles or the budget runs out.
    task automatic run_meas(input int h, input int d, input bit interfere, input int gap);
        int k;
        m_rise = -1; m_width = 0; m_npronto = 0; m_pronto_k = -1; m_nerro = 0; m_nocup = 0;
        distancia = LD'(d);
        @(negedge clock); trigger = 1'b1;
        repeat (h) @(negedge clock);
        trigger = 1'b0;
        k = 0;
        while (k < BUDGET) begin
            @(negedge clock); k++;
            if (echo) begin if (m_rise < 0) m_rise = k; m_width++; end
            if (pronto) begin m_npronto++; if (m_pronto_k < 0) m_pronto_k = k; end
            if (erro_trigger) m_nerro++;
            if (ocupado) m_nocup++;
            if (interfere && m_rise > 0) begin
                if (k == m_rise + 2) begin distancia = LD'(7); trigger = 1'b1; end
                if (k == m_rise + 8) trigger = 1'b0;
            end
            if (m_pronto_k >= 0 && k >= m_pronto_k + 2) break;
        end
        trigger = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; trigger = 1'b1; distancia = LD'(3);
        repeat (3) @(negedge clock);
        vectors++;
        if ({echo, ocupado, pronto, erro_trigger} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000", {echo, ocupado, pronto, erro_trigger});
        end
        vectors++;
        if (db_estado !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", db_estado);
        end
        reset = 1'b1;
        run_meas(6, 3, 1'b0, GAP);
        vectors++;
        if (m_width !== exp_width(3) || m_npronto !== 1) begin
            miscompares++;
            $display("FAIL reset_release_meas: width %0d pronto %0d expected %0d/1", m_width, m_npronto, exp_width(3));
        end
    endtask

    task automatic test_nominal;
        run_meas(6, 3, 1'b0, GAP);
        vectors++;
        if (m_rise !== LAT) begin
            miscompares++;
            $display("FAIL nominal_rise: got %0d expected %0d", m_rise, LAT);
        end
        vectors++;
        if (m_width !== 12) begin
            miscompares++;
            $display("FAIL nominal_width: got %0d expected 12", m_width);
        end
        vectors++;
        if (m_npronto !== 1 || m_pronto_k !== LAT + 12) begin
            miscompares++;
            $display("FAIL nominal_pronto: count %0d at %0d expected 1 at %0d", m_npronto, m_pronto_k, LAT + 12);
        end
        vectors++;
        if (m_nocup !== ATR + 12 + 1) begin
            miscompares++;
            $display("FAIL nominal_ocupado: got %0d cycles expected %0d", m_nocup, ATR + 13);
        end
        vectors++;
        if (m_nerro !== 0 || db_estado !== 3'd0) begin
            miscompares++;
            $display("FAIL nominal_end: erro %0d state %0d expected 0/0", m_nerro, db_estado);
        end
    endtask

    task automatic test_short_trigger;
        run_meas(3, 3, 1'b0, GAP);
        vectors++;
        if (m_nerro !== 1) begin
            miscompares++;
            $display("FAIL short_erro: got %0d pulses expected 1", m_nerro);
        end
        vectors++;
        if (m_rise !== -1 || m_npronto !== 0) begin
            miscompares++;
            $display("FAIL short_no_echo: rise %0d pronto %0d expected -1/0", m_rise, m_npronto);
        end
        vectors++;
        if (db_estado !== 3'd0) begin
            miscompares++;
            $display("FAIL short_state: got %0d expected 0", db_estado);
        end
        run_meas(MINT, 2, 1'b0, GAP);
        vectors++;
        if (m_width !== exp_width(2) || m_nerro !== 0) begin
            miscompares++;
            $display("FAIL min_trigger_accept: width %0d erro %0d expected %0d/0", m_width, m_nerro, exp_width(2));
        end
        run_meas(MINT - 1, 2, 1'b0, GAP);
        vectors++;
        if (m_rise !== -1 || m_nerro !== 1) begin
            miscompares++;
            $display("FAIL min_trigger_reject: rise %0d erro %0d expected -1/1", m_rise, m_nerro);
        end
    endtask

    task automatic test_saturation_zero;
        run_meas(6, 25, 1'b0, GAP);
        vectors++;
        if (m_width !== 40) begin
            miscompares++;
            $display("FAIL saturation_width: got %0d expected 40", m_width);
        end
        run_meas(6, 0, 1'b0, GAP);
        vectors++;
        if (m_width !== 4) begin
            miscompares++;
            $display("FAIL zero_width: got %0d expected 4", m_width);
        end
        run_meas(6, MAXC, 1'b0, GAP);
        vectors++;
        if (m_width !== MAXC * TPC) begin
            miscompares++;
            $display("FAIL max_width: got %0d expected %0d", m_width, MAXC * TPC);
        end
    endtask

    task automatic test_interference;
        run_meas(6, 3, 1'b1, GAP);
        vectors++;
        if (m_width !== 12 || m_npronto !== 1) begin
            miscompares++;
            $display("FAIL interference: width %0d pronto %0d expected 12/1", m_width, m_npronto);
        end
        vectors++;
        if (m_nerro !== 0 || db_estado !== 3'd0) begin
            miscompares++;
            $display("FAIL interference_end: erro %0d state %0d expected 0/0", m_nerro, db_estado);
        end
    endtask

    task automatic test_reset_mid_echo;
        int n;
        int np;
        n = 0; np = 0;
        distancia = LD'(3);
        @(negedge clock); trigger = 1'b1;
        repeat (6) @(negedge clock);
        trigger = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clock);
            if (echo) n++;
            if (n == 5) break;
        end
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL mid_echo_reach: echo cycles %0d expected 5", n);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (echo !== 1'b0 || ocupado !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_echo_drop: echo %b ocupado %b expected 0/0", echo, ocupado);
        end
        repeat (3) begin @(negedge clock); if (pronto) np++; end
        reset = 1'b1;
        repeat (20) begin @(negedge clock); if (pronto || echo) np++; end
        vectors++;
        if (np !== 0) begin
            miscompares++;
            $display("FAIL mid_echo_no_pronto: got %0d activity cycles expected 0", np);
        end
        run_meas(6, 3, 1'b0, GAP);
        vectors++;
        if (m_width !== 12 || m_npronto !== 1) begin
            miscompares++;
            $display("FAIL after_reset_meas: width %0d pronto %0d expected 12/1", m_width, m_npronto);
        end
    endtask

`ifdef ECO_HOLDOFF_EN
    task automatic test_holdoff;
        run_meas(6, 2, 1'b0, 0);
        run_meas(6, 2, 1'b0, GAP);
        vectors++;
        if (m_rise !== -1 || m_nerro !== 0 || m_nocup !== 0) begin
            miscompares++;
            $display("FAIL holdoff_ignore: rise %0d erro %0d ocupado %0d expected -1/0/0", m_rise, m_nerro, m_nocup);
        end
        run_meas(6, 2, 1'b0, GAP);
        vectors++;
        if (m_width !== exp_width(2)) begin
            miscompares++;
            $display("FAIL holdoff_after: width %0d expected %0d", m_width, exp_width(2));
        end
    endtask
`endif

    task automatic test_random;
        int d;
        int h;
        for (int i = 0; i < 25; i++) begin
            d = int'($urandom_range(0, 31));
            h = int'($urandom_range(1, 9));
            run_meas(h, d, 1'b0, GAP);
            vectors++;
            if (h >= MINT) begin
                if (m_rise !== LAT || m_width !== exp_width(d) || m_npronto !== 1 || m_nerro !== 0) begin
                    miscompares++;
                    $display("FAIL random_accept d=%0d h=%0d: rise %0d width %0d pronto %0d erro %0d expected %0d/%0d/1/0",
                             d, h, m_rise, m_width, m_npronto, m_nerro, LAT, exp_width(d));
                end
            end else begin
                if (m_rise !== -1 || m_npronto !== 0 || m_nerro !== 1) begin
                    miscompares++;
                    $display("FAIL random_reject d=%0d h=%0d: rise %0d pronto %0d erro %0d expected -1/0/1",
                             d, h, m_rise, m_npronto, m_nerro);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_short_trigger;
        test_saturation_zero;
        test_interference;
        test_reset_mid_echo;
`ifdef ECO_HOLDOFF_EN
        test_holdoff;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
